// File: rtl/matmul_pkg.sv
// +-----------------------------------------------------------------------------+
// | matmul_pkg : shared sizes, operand types and helpers of the matmul datapath |
// | Revision   : 1.0                                                            |
// +-----------------------------------------------------------------------------+
`default_nettype none

package matmul_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int BUS_WIDTH  = 64;
  localparam int MAX_DIM    = BUS_WIDTH / DATA_WIDTH;
  localparam int DIM_W      = $clog2(MAX_DIM) + 1;
  localparam int STEP_W     = $clog2(2 * MAX_DIM);
  localparam int IDX_W      = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1;

  // Row-major: mat[i][j] is row i, column j.
  typedef logic [MAX_DIM-1:0][MAX_DIM-1:0][DATA_WIDTH-1:0] matA;
  typedef logic [MAX_DIM-1:0][MAX_DIM-1:0][DATA_WIDTH-1:0] matB;

  typedef logic [DATA_WIDTH-1:0] vecw_t [MAX_DIM-1:0];

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FEED = 2'd1,
    DONE = 2'd2
  } feeder_state_t;

  function automatic logic dimLegal(input logic [DIM_W-1:0] d);
    return (d != '0) && (int'(d) <= MAX_DIM);
  endfunction

  // Index of the final skew step: K + MAX_DIM - 1 steps in total.
  function automatic logic [STEP_W-1:0] lastStep(input logic [DIM_W-1:0] k);
    return STEP_W'(int'(k) + MAX_DIM - 2);
  endfunction

endpackage

`default_nettype wire

// File: rtl/matmul_operand_feeder_if.sv
// +-----------------------------------------------------------------------------+
// | matmul_operand_feeder_if : operand capture and skewed-stream bus            |
// | Revision                 : 1.0                                              |
// +-----------------------------------------------------------------------------+
`default_nettype none

interface matmul_operand_feeder_if;
  import matmul_pkg::*;

  logic             start_i;
  logic [DIM_W-1:0] n_dim_i;
  logic [DIM_W-1:0] k_dim_i;
  logic [DIM_W-1:0] m_dim_i;
  matA              mat_a_i;
  matB              mat_b_i;
  logic             ready_i;
  vecw_t            a_o;
  vecw_t            b_o;
  logic             valid_o;
  logic             first_o;
  logic             last_o;
  logic             busy_o;
  logic             done_o;
  logic             err_o;

  modport master (
    output start_i, n_dim_i, k_dim_i, m_dim_i, mat_a_i, mat_b_i, ready_i,
    input  a_o, b_o, valid_o, first_o, last_o, busy_o, done_o, err_o
  );

  modport slave (
    input  start_i, n_dim_i, k_dim_i, m_dim_i, mat_a_i, mat_b_i, ready_i,
    output a_o, b_o, valid_o, first_o, last_o, busy_o, done_o, err_o
  );

endinterface

`default_nettype wire

// File: rtl/matmul_skew_mux.sv
// +-----------------------------------------------------------------------------+
// | matmul_skew_mux : selects the diagonally skewed, dimension-masked word of   |
// |                   one array lane (row of A, or column of B when transposed) |
// | Revision        : 1.0                                                       |
// +-----------------------------------------------------------------------------+
`default_nettype none

module matmul_skew_mux
  import matmul_pkg::*;
(
  input  matA                   mat,
  input  logic                  transpose,
  input  logic [IDX_W-1:0]      idx,
  input  logic [STEP_W-1:0]     step,
  input  logic [DIM_W-1:0]      limLane,
  input  logic [DIM_W-1:0]      limK,
  output logic [DATA_WIDTH-1:0] word
);

  localparam int c_diffW = STEP_W + 1;

  logic [STEP_W:0]   w_diff;
  logic [STEP_W-1:0] w_offset;
  logic [IDX_W-1:0]  w_sel;
  logic              w_inRange;

  // Lane idx is delayed by idx steps; the extra diff bit flags step < idx.
  always_comb begin
    w_diff    = {1'b0, step} - c_diffW'(idx);
    w_offset  = w_diff[STEP_W-1:0];
    w_sel     = w_offset[IDX_W-1:0];
    w_inRange = !w_diff[STEP_W]
              && (int'(idx) < int'(limLane))
              && (int'(w_offset) < int'(limK));
    word = '0;
    if (w_inRange) begin
      word = transpose ? mat[w_sel][idx] : mat[idx][w_sel];
    end
  end

endmodule

`default_nettype wire

// File: rtl/matmul_operand_feeder.sv
// +-----------------------------------------------------------------------------+
// | matmul_operand_feeder : captures an A/B operand pair and streams it into    |
// |                         the systolic array in diagonal-skew order           |
// | Revision              : 1.0                                                 |
// +-----------------------------------------------------------------------------+
`default_nettype none

module matmul_operand_feeder
  import matmul_pkg::*;
(
  input logic                    clk_i,
  input logic                    rst_ni,
  matmul_operand_feeder_if.slave bus
);

  localparam logic [1:0] c_stIdle = IDLE;
  localparam logic [1:0] c_stFeed = FEED;
  localparam logic [1:0] c_stDone = DONE;

  logic [1:0]        r_state;
  logic [STEP_W-1:0] r_step;
  matA               r_matA;
  matB               r_matB;
  logic [DIM_W-1:0]  r_n;
  logic [DIM_W-1:0]  r_k;
  logic [DIM_W-1:0]  r_m;
  vecw_t             r_a;
  vecw_t             r_b;
  logic              r_valid;
  logic              r_first;
  logic              r_last;
  logic              r_busy;
  logic              r_done;
  logic              r_err;

  logic [1:0]        w_stateNext;
  logic [STEP_W-1:0] w_stepNext;
  logic              w_accept;
  logic              w_err;
  logic              w_feedNext;
  matA               w_matANext;
  matB               w_matBNext;
  logic [DIM_W-1:0]  w_nNext;
  logic [DIM_W-1:0]  w_kNext;
  logic [DIM_W-1:0]  w_mNext;
  vecw_t             w_skewA;
  vecw_t             w_skewB;

  always_comb begin
    w_stateNext = r_state;
    w_stepNext  = r_step;
    w_accept    = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      c_stIdle: begin
        if (bus.start_i) begin
          if (dimLegal(bus.n_dim_i) && dimLegal(bus.k_dim_i) && dimLegal(bus.m_dim_i)) begin
            w_accept    = 1'b1;
            w_stepNext  = '0;
            w_stateNext = c_stFeed;
          end else begin
            w_err = 1'b1;
          end
        end
      end
      c_stFeed: begin
        if (bus.ready_i) begin
          if (r_step == lastStep(r_k)) begin
            w_stateNext = c_stDone;
          end else begin
            w_stepNext = r_step + STEP_W'(1);
          end
        end
      end
      c_stDone: w_stateNext = c_stIdle;
      default:  w_stateNext = c_stIdle;
    endcase
  end

  // Outputs are registered, so the lane muxes look at next-cycle operands and step.
  always_comb begin
    w_feedNext = (w_stateNext == c_stFeed);
    w_matANext = w_accept ? bus.mat_a_i : r_matA;
    w_matBNext = w_accept ? bus.mat_b_i : r_matB;
    w_nNext    = w_accept ? bus.n_dim_i : r_n;
    w_kNext    = w_accept ? bus.k_dim_i : r_k;
    w_mNext    = w_accept ? bus.m_dim_i : r_m;
  end

  generate
    for (genvar g = 0; g < MAX_DIM; g++) begin : g_lane
      localparam logic [IDX_W-1:0] c_lane = IDX_W'(g);

      matmul_skew_mux u_muxA (
        .mat       (w_matANext),
        .transpose (1'b0),
        .idx       (c_lane),
        .step      (w_stepNext),
        .limLane   (w_nNext),
        .limK      (w_kNext),
        .word      (w_skewA[g])
      );

      matmul_skew_mux u_muxB (
        .mat       (w_matBNext),
        .transpose (1'b1),
        .idx       (c_lane),
        .step      (w_stepNext),
        .limLane   (w_mNext),
        .limK      (w_kNext),
        .word      (w_skewB[g])
      );
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= c_stIdle;
      r_step  <= '0;
      r_matA  <= '0;
      r_matB  <= '0;
      r_n     <= '0;
      r_k     <= '0;
      r_m     <= '0;
      r_valid <= 1'b0;
      r_first <= 1'b0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      for (int i = 0; i < MAX_DIM; i++) begin
        r_a[i] <= '0;
        r_b[i] <= '0;
      end
    end else begin
      r_state <= w_stateNext;
      r_step  <= w_stepNext;
      if (w_accept) begin
        r_matA <= bus.mat_a_i;
        r_matB <= bus.mat_b_i;
        r_n    <= bus.n_dim_i;
        r_k    <= bus.k_dim_i;
        r_m    <= bus.m_dim_i;
      end
      r_valid <= w_feedNext;
      r_busy  <= w_feedNext;
      r_first <= w_feedNext && (w_stepNext == '0);
      r_last  <= w_feedNext && (w_stepNext == lastStep(w_kNext));
      r_done  <= (w_stateNext == c_stDone);
      r_err   <= w_err;
      for (int i = 0; i < MAX_DIM; i++) begin
        r_a[i] <= w_feedNext ? w_skewA[i] : '0;
        r_b[i] <= w_feedNext ? w_skewB[i] : '0;
      end
    end
  end

  assign bus.a_o     = r_a;
  assign bus.b_o     = r_b;
  assign bus.valid_o = r_valid;
  assign bus.first_o = r_first;
  assign bus.last_o  = r_last;
  assign bus.busy_o  = r_busy;
  assign bus.done_o  = r_done;
  assign bus.err_o   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_matmul_operand_feeder.sv
// +-----------------------------------------------------------------------------+
// | tb_matmul_operand_feeder : directed and randomized bench for the feeder     |
// | Revision                 : 1.0                                              |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_matmul_operand_feeder;
  import matmul_pkg::*;

  logic clk = 1'b0;
  logic rst_ni;
  always #5 clk = ~clk;

  matmul_operand_feeder_if ifc ();

  matmul_operand_feeder dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (ifc)
  );

  int checks   = 0;
  int failures = 0;

  logic [DATA_WIDTH-1:0] tA [MAX_DIM][MAX_DIM];
  logic [DATA_WIDTH-1:0] tB [MAX_DIM][MAX_DIM];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chkQuiet(input string tag);
    chk({tag, "_valid"}, 64'(ifc.valid_o), 64'd0);
    chk({tag, "_busy"},  64'(ifc.busy_o),  64'd0);
    chk({tag, "_first"}, 64'(ifc.first_o), 64'd0);
    chk({tag, "_last"},  64'(ifc.last_o),  64'd0);
    chk({tag, "_done"},  64'(ifc.done_o),  64'd0);
    chk({tag, "_err"},   64'(ifc.err_o),   64'd0);
    for (int l = 0; l < MAX_DIM; l++) begin
      chk($sformatf("%s_a%0d", tag, l), 64'(ifc.a_o[l]), 64'd0);
      chk($sformatf("%s_b%0d", tag, l), 64'(ifc.b_o[l]), 64'd0);
    end
  endtask

  task automatic driveStart(input int n, input int k, input int m);
    ifc.start_i = 1'b1;
    ifc.n_dim_i = DIM_W'(n);
    ifc.k_dim_i = DIM_W'(k);
    ifc.m_dim_i = DIM_W'(m);
    for (int i = 0; i < MAX_DIM; i++)
      for (int j = 0; j < MAX_DIM; j++) begin
        ifc.mat_a_i[i][j] = tA[i][j];
        ifc.mat_b_i[i][j] = tB[i][j];
      end
  endtask

  // Called at a negedge; returns at the negedge of the IDLE cycle after done_o.
  task automatic runOp(input string tag, input int n, input int k, input int m,
                       input int stallAt, input int stallN, input bit pulseStart);
    logic [DATA_WIDTH-1:0] eA [2*MAX_DIM][MAX_DIM];
    logic [DATA_WIDTH-1:0] eB [2*MAX_DIM][MAX_DIM];
    int  nSteps, step, cyc, left;
    bit  pulsed;
    nSteps = k + MAX_DIM - 1;
    for (int t = 0; t < 2*MAX_DIM; t++)
      for (int l = 0; l < MAX_DIM; l++) begin
        eA[t][l] = '0;
        eB[t][l] = '0;
      end
    // Scatter each element to the step where it enters its lane.
    for (int i = 0; i < n; i++)
      for (int kk = 0; kk < k; kk++) eA[i+kk][i] = tA[i][kk];
    for (int j = 0; j < m; j++)
      for (int kk = 0; kk < k; kk++) eB[kk+j][j] = tB[kk][j];

    driveStart(n, k, m);
    ifc.ready_i = 1'b1;
    @(negedge clk);
    ifc.start_i = 1'b0;
    step = 0; cyc = 0; left = stallN; pulsed = 1'b0;
    while (step < nSteps && cyc < 64) begin
      chk($sformatf("%s_valid_t%0d", tag, step), 64'(ifc.valid_o), 64'd1);
      chk($sformatf("%s_busy_t%0d",  tag, step), 64'(ifc.busy_o),  64'd1);
      chk($sformatf("%s_first_t%0d", tag, step), 64'(ifc.first_o), 64'(step == 0));
      chk($sformatf("%s_last_t%0d",  tag, step), 64'(ifc.last_o),  64'(step == nSteps-1));
      chk($sformatf("%s_done_t%0d",  tag, step), 64'(ifc.done_o),  64'd0);
      for (int l = 0; l < MAX_DIM; l++) begin
        chk($sformatf("%s_a%0d_t%0d", tag, l, step), 64'(ifc.a_o[l]), 64'(eA[step][l]));
        chk($sformatf("%s_b%0d_t%0d", tag, l, step), 64'(ifc.b_o[l]), 64'(eB[step][l]));
      end
      if (pulseStart && step == 1 && !pulsed) begin
        ifc.start_i = 1'b1;
        ifc.mat_a_i = {$urandom, $urandom, $urandom, $urandom};
        ifc.mat_b_i = {$urandom, $urandom, $urandom, $urandom};
        pulsed = 1'b1;
      end else begin
        ifc.start_i = 1'b0;
      end
      if (step == stallAt && left > 0) begin
        ifc.ready_i = 1'b0;
        left--;
      end else begin
        ifc.ready_i = 1'b1;
        step++;
      end
      @(negedge clk);
      cyc++;
    end
    ifc.start_i = 1'b0;
    ifc.ready_i = 1'b1;
    chk({tag, "_stepsIssued"}, 64'(step), 64'(nSteps));
    chk({tag, "_cycles"}, 64'(cyc), 64'(nSteps + ((stallAt >= 0 && stallAt < nSteps) ? stallN : 0)));
    chk({tag, "_done"},  64'(ifc.done_o),  64'd1);
    chk({tag, "_doneValid"}, 64'(ifc.valid_o), 64'd0);
    chk({tag, "_doneBusy"},  64'(ifc.busy_o),  64'd0);
    chk({tag, "_doneA0"},    64'(ifc.a_o[0]),  64'd0);
    chk({tag, "_doneErr"},   64'(ifc.err_o),   64'd0);
    @(negedge clk);
    chkQuiet({tag, "_idle"});
  endtask

  task automatic errReq(input string tag, input int n, input int k, input int m);
    driveStart(n, k, m);
    @(negedge clk);
    ifc.start_i = 1'b0;
    chk({tag, "_err"},   64'(ifc.err_o),   64'd1);
    chk({tag, "_busy"},  64'(ifc.busy_o),  64'd0);
    chk({tag, "_valid"}, 64'(ifc.valid_o), 64'd0);
    @(negedge clk);
    chkQuiet({tag, "_after"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, k, m, sAt, sN, which, bad;
    rst_ni      = 1'b0;
    ifc.start_i = 1'b0;
    ifc.ready_i = 1'b1;
    ifc.n_dim_i = '0;
    ifc.k_dim_i = '0;
    ifc.m_dim_i = '0;
    ifc.mat_a_i = '0;
    ifc.mat_b_i = '0;
    repeat (3) @(negedge clk);
    chkQuiet("reset");
    rst_ni = 1'b1;
    @(negedge clk);
    chkQuiet("postReset");

    tA[0][0] = 1; tA[0][1] = 2; tA[1][0] = 3; tA[1][1] = 4;
    tB[0][0] = 5; tB[0][1] = 6; tB[1][0] = 7; tB[1][1] = 8;
    runOp("full",   2, 2, 2, -1, 0, 1'b0);
    runOp("stall",  2, 2, 2,  1, 3, 1'b0);
    runOp("narrow", 1, 2, 1, -1, 0, 1'b0);
    errReq("errK0M3", 1, 0, 3);
    runOp("ignStart", 2, 2, 2, -1, 0, 1'b1);

    // Reset during step 1 of a running operation.
    driveStart(2, 2, 2);
    @(negedge clk);
    ifc.start_i = 1'b0;
    chk("rstMid_t0first", 64'(ifc.first_o), 64'd1);
    @(negedge clk);
    chk("rstMid_t1a0", 64'(ifc.a_o[0]), 64'd2);
    rst_ni = 1'b0;
    @(negedge clk);
    chkQuiet("rstMid");
    rst_ni = 1'b1;
    @(negedge clk);
    chkQuiet("rstMidRel");
    runOp("afterRst", 2, 2, 2, -1, 0, 1'b0);

    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < MAX_DIM; i++)
        for (int j = 0; j < MAX_DIM; j++) begin
          tA[i][j] = $urandom;
          tB[i][j] = $urandom;
        end
      n = $urandom_range(1, MAX_DIM);
      k = $urandom_range(1, MAX_DIM);
      m = $urandom_range(1, MAX_DIM);
      if ($urandom_range(0, 4) == 0) begin
        which = $urandom_range(0, 2);
        bad   = ($urandom_range(0, 1) == 0) ? 0 : MAX_DIM + 1;
        if (which == 0) n = bad;
        else if (which == 1) k = bad;
        else m = bad;
        errReq($sformatf("rndErr%0d", r), n, k, m);
      end else begin
        sAt = $urandom_range(0, 3);
        sN  = $urandom_range(0, 3);
        runOp($sformatf("rnd%0d", r), n, k, m, sAt, sN, $urandom_range(0, 3) == 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/matmul_operand_feeder.md
Name: matmul_operand_feeder

Overview:
- Upstream stage of the matmul compute array.
- Captures one operand pair (matrix A, matrix B, each MAX_DIM x MAX_DIM words) on a start strobe.
- Streams the pair into the array in systolic diagonal-skew order: row i of A and column j of B are delayed i and j steps respectively.
- Generates first/last framing and a done strobe, and honours back-pressure from the array.

Parameters:
- DATA_WIDTH, 32, operand word width (from matmul_pkg).
- BUS_WIDTH, 64, bus width; sets MAX_DIM = BUS_WIDTH/DATA_WIDTH = 2 (from matmul_pkg).
- DIM_W, $clog2(MAX_DIM)+1, width of the runtime dimension inputs.
- STEP_W, $clog2(2*MAX_DIM), width of the skew step counter.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, synchronous, active-low.
- start_i  in  1  start request; accepted only in IDLE.
- n_dim_i  in  DIM_W  rows of A in use (1..MAX_DIM).
- k_dim_i  in  DIM_W  columns of A = rows of B (1..MAX_DIM).
- m_dim_i  in  DIM_W  columns of B in use (1..MAX_DIM).
- mat_a_i  in  matA  operand A, sampled on start acceptance.
- mat_b_i  in  matB  operand B, sampled on start acceptance.
- ready_i  in  1  array can accept the current step.
- a_o  out  MAX_DIM x DATA_WIDTH  skewed A word per array row.
- b_o  out  MAX_DIM x DATA_WIDTH  skewed B word per array column.
- valid_o  out  1  a_o/b_o hold a valid step.
- first_o  out  1  step 0; array clears its accumulators.
- last_o  out  1  final step of the operation.
- busy_o  out  1  operation in progress.
- done_o  out  1  one-cycle completion pulse.
- err_o  out  1  one-cycle illegal-dimension pulse.

Behaviour:
- Reset: while rst_ni=0 at a clock edge, go to IDLE. All outputs become 0, the step counter becomes 0, captured operands become 0. Reset overrides everything, including mid-FEED; no done_o is issued for an aborted operation.
- All outputs are registered.
- States: IDLE, FEED, DONE.
- IDLE, start_i=1, all dims in 1..MAX_DIM:
  - capture mat_a_i, mat_b_i, n/k/m;
  - step t=0; go to FEED;
  - next cycle: busy_o=1, valid_o=1, first_o=1.
- IDLE, start_i=1, any dim =0 or >MAX_DIM: err_o=1 for exactly one cycle; remain IDLE; nothing is captured.
- FEED:
  - Outputs for step t:
    - a_o[i] = A[i][t-i] if i<N and 0<=t-i<K, else 0;
    - b_o[j] = B[t-j][j] if j<M and 0<=t-j<K, else 0.
  - Total steps S = K+MAX_DIM-1. Skew depth is fixed by the array, not by N/M.
  - first_o=1 only at t=0; last_o=1 only at t=S-1.
  - Handshake: a step is consumed on a cycle where valid_o & ready_i.
    - ready_i=0: hold a_o, b_o, first_o, last_o and t unchanged.
    - Consumed, t<S-1: t+1.
    - Consumed, t=S-1: go to DONE.
- DONE: valid_o=0, busy_o=0, a_o/b_o=0, done_o=1 for one cycle; next cycle IDLE.
- start_i while in FEED or DONE is ignored; it is not queued.
- Earliest back-to-back operation: start accepted in the cycle after done_o.
- err_o and done_o never coincide.
- Latency with ready_i held at 1:
  - start accepted at edge 0;
  - valid_o from cycle 1 for S cycles;
  - done_o at cycle S+1.

Decomposition:
- matmul_pkg already holds DATA_WIDTH, BUS_WIDTH, MAX_DIM, matA, matB.
- Add to matmul_pkg:
  - localparam DIM_W, STEP_W;
  - typedef logic [DATA_WIDTH-1:0] vecw_t [MAX_DIM-1:0] for a_o/b_o;
  - enum feeder_state_t {IDLE, FEED, DONE}.
- One sub-module: matmul_skew_mux. It is combinational: given the captured matrix, t, index and the dim limits, it returns the masked skewed word. It is instantiated per row for A and per column for B, with a transpose flag for B.

Test Plan (MAX_DIM=2):
- Full 2x2x2, ready_i=1, A=[[1,2],[3,4]], B=[[5,6],[7,8]] -> expect:
  - t0: a=(1,0), b=(5,0), first_o=1;
  - t1: a=(2,3), b=(7,6);
  - t2: a=(0,4), b=(0,8), last_o=1;
  - done_o one cycle later.
- Same operands, ready_i=0 during t1 for 3 cycles -> a=(2,3), b=(7,6) held stable 4 cycles; then t2 as above; done_o delayed by 3 cycles.
- N=1, K=2, M=1 -> a_o[1] and b_o[1] always 0; 3 steps still issued; t1: a=(2,0), b=(7,0).
- k_dim_i=0 (also m_dim_i=3) with start_i -> err_o single-cycle pulse; busy_o, valid_o stay 0.
- start_i pulsed at t1 of a running op -> ignored; exactly one done_o.
- rst_ni=0 at t1 -> next cycle all outputs 0, IDLE. A new start after release runs cleanly from t0.
